// File: rtl/updown_arbiter_if.sv
// updown_arbiter_if: request/grant/count bundle shared by the agents and updown_arbiter
//   master: drives req0/dir0/steps0, req1/dir1/steps1; observes gnt0/gnt1, done0/done1, busy, cnt_out
//   slave : the arbiter side, mirror of master
interface updown_arbiter_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
);
    logic              req0;
    logic              dir0;
    logic [STEP_W-1:0] steps0;
    logic              req1;
    logic              dir1;
    logic [STEP_W-1:0] steps1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic              busy;
    logic [WIDTH-1:0]  cnt_out;
    modport master (
        output req0, dir0, steps0, req1, dir1, steps1,
        input  gnt0, gnt1, done0, done1, busy, cnt_out
    );
    modport slave (
        input  req0, dir0, steps0, req1, dir1, steps1,
        output gnt0, gnt1, done0, done1, busy, cnt_out
    );
endinterface

// File: rtl/updown_arbiter.sv
// updown_arbiter: round-robin shared up/down counter running step bursts for two requesters
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : updown_arbiter_if.slave (requests in; grants, done pulses, busy, count out)
//   UPDOWN_ARB_SAT_EN defined selects saturating steps instead of modulo wrap
module updown_arbiter #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input logic               clk,
    input logic               reset,
    updown_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              own_q, own_d;
    logic              dir_q, dir_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d, cnt_step;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              busy_q;
    logic              own_req, win;
    logic [STEP_W-1:0] win_steps;
    // ptr_q names the requester favoured on a tie: the one not served last
    assign win       = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
    assign win_steps = win ? bus.steps1 : bus.steps0;
    assign own_req   = own_q ? bus.req1 : bus.req0;
`ifdef UPDOWN_ARB_SAT_EN
    assign cnt_step = dir_q ? ((cnt_q == '0) ? cnt_q : cnt_q - 1'b1)
                            : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
`else
    assign cnt_step = dir_q ? cnt_q - 1'b1 : cnt_q + 1'b1;
`endif
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        case (state_q)
            IDLE: if (bus.req0 || bus.req1) begin
                own_d   = win;
                dir_d   = win ? bus.dir1 : bus.dir0;
                rem_d   = win_steps;
                gnt0_d  = !win;
                gnt1_d  = win;
                state_d = (win_steps == '0) ? DONE : RUN;
                done0_d = (win_steps == '0) && !win;
                done1_d = (win_steps == '0) && win;
            end
            RUN: if (!own_req) begin
                // abort: no step, no done, but the other side still gets priority
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                ptr_d   = !own_q;
            end else begin
                cnt_d   = cnt_step;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == STEP_W'(1)) ? DONE : RUN;
                done0_d = (rem_q == STEP_W'(1)) && !own_q;
                done1_d = (rem_q == STEP_W'(1)) && own_q;
            end
            DONE: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                ptr_d   = !own_q;
            end
            default: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            own_q   <= 1'b0;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= (state_d != IDLE);
        end
    end
    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.busy    = busy_q;
    assign bus.cnt_out = cnt_q;
endmodule
